// File: rtl/bvuge_bvadd_witness_checker_if.sv
// Request/response bundle for the bvuge/bvadd Skolem witness checker.
// master: request producer and result consumer (drives in_valid, s, t, x, out_ready).
// slave:  the checker (drives in_ready, out_valid, result fields and statistics).
interface bvuge_bvadd_witness_checker_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  s;
    logic [W-1:0]  t;
    logic [W-1:0]  x;
    logic          out_valid;
    logic          out_ready;
    logic          cand_ok;
    logic          exists;
    logic [W-1:0]  min_x;
    logic [W:0]    sat_count;
    logic          error;
    logic [CW-1:0] chk_count;
    logic [CW-1:0] err_count;

    modport master (
        output in_valid, s, t, x, out_ready,
        input  in_ready, out_valid, cand_ok, exists, min_x, sat_count, error,
               chk_count, err_count
    );

    modport slave (
        input  in_valid, s, t, x, out_ready,
        output in_ready, out_valid, cand_ok, exists, min_x, sat_count, error,
               chk_count, err_count
    );
endinterface

// File: rtl/bvuge_bvadd_witness_checker.sv
// Checks a Skolem witness x for the constraint ((x + s) mod 2^W) >= t (unsigned)
// and, by sweeping every W-bit value, reports whether any witness exists, the
// smallest one and how many there are. Keeps saturating result/error counters.
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of the
// request/response interface: in_valid/in_ready, s/t/x, out_valid/out_ready,
// cand_ok, exists, min_x, sat_count, error, chk_count, err_count).
module bvuge_bvadd_witness_checker #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    bvuge_bvadd_witness_checker_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, RESP} state_t;

    // Index is one bit wider than the operands so the end of sweep is unambiguous.
    localparam logic [W:0] LAST_IDX = (W+1)'((1 << W) - 1);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] s_q;
    logic [W-1:0] t_q;
    logic [W-1:0] x_q;
    logic [W:0]   idx;
    logic [W-1:0] sum_c;
    logic         hit_c;
    logic         last_c;
    logic         accept_c;
    logic         done_c;

    assign sum_c    = W'(idx[W-1:0] + s_q);
    assign hit_c    = sum_c >= t_q;
    assign last_c   = idx == LAST_IDX;
    assign accept_c = bus.in_valid && (state == IDLE);
    assign done_c   = bus.out_ready && (state == RESP);

    // Result fields are all registers, so error is stable whenever they are.
    assign bus.error = bus.exists & ~bus.cand_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = SWEEP;
            SWEEP:   if (last_c)       state_nxt = RESP;
            RESP:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            RESP:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, one-index-per-cycle sweep and statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q           <= '0;
            t_q           <= '0;
            x_q           <= '0;
            idx           <= '0;
            bus.cand_ok   <= 1'b0;
            bus.exists    <= 1'b0;
            bus.min_x     <= '0;
            bus.sat_count <= '0;
            bus.chk_count <= '0;
            bus.err_count <= '0;
        end else begin
            if (accept_c) begin
                s_q           <= bus.s;
                t_q           <= bus.t;
                x_q           <= bus.x;
                idx           <= '0;
                bus.cand_ok   <= 1'b0;
                bus.exists    <= 1'b0;
                bus.min_x     <= '0;
                bus.sat_count <= '0;
            end else if (state == SWEEP) begin
                idx <= idx + (W+1)'(1);
                // Candidate is judged from the captured operands on the first sweep cycle.
                if (idx == '0) bus.cand_ok <= W'(x_q + s_q) >= t_q;
                if (hit_c) begin
                    bus.sat_count <= bus.sat_count + (W+1)'(1);
                    if (!bus.exists) begin
                        bus.exists <= 1'b1;
                        bus.min_x  <= idx[W-1:0];
                    end
                end
            end

            if (done_c) begin
                if (bus.chk_count != '1) bus.chk_count <= bus.chk_count + CW'(1);
                if (bus.error && (bus.err_count != '1)) bus.err_count <= bus.err_count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bvuge_bvadd_witness_checker.sv
// Directed bench for bvuge_bvadd_witness_checker: hand-computed vectors,
// backpressure, reset mid-sweep and counter saturation.
module tb_bvuge_bvadd_witness_checker;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bvuge_bvadd_witness_checker_if #(.W(W), .CW(CW)) bus ();

    bvuge_bvadd_witness_checker #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present a request and return just after the accepting edge.
    task automatic accept(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
        @(negedge clk);
        bus.s        = s;
        bus.t        = t;
        bus.x        = x;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic cand, input logic [3:0] mn,
                                input logic [4:0] cnt);
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_cand_ok"},   bus.cand_ok, cand);
        check({tag, "_exists"},    bus.exists, 1);
        check({tag, "_min_x"},     bus.min_x, mn);
        check({tag, "_sat_count"}, bus.sat_count, cnt);
        check({tag, "_error"},     bus.error, !cand);
    endtask

    task automatic run_vec(input string tag, input logic [3:0] s, input logic [3:0] t,
                           input logic [3:0] x, input logic cand, input logic [3:0] mn,
                           input logic [4:0] cnt, input int chk, input int err);
        int n;
        accept(s, t, x);
        check({tag, "_in_ready_busy"}, bus.in_ready, 0);
        wait_resp(n);
        check({tag, "_latency"}, n, 16);
        check_result(tag, cand, mn, cnt);
        handshake();
        check({tag, "_out_valid_after"}, bus.out_valid, 0);
        check({tag, "_in_ready_after"},  bus.in_ready, 1);
        check({tag, "_chk_count"}, bus.chk_count, chk);
        check({tag, "_err_count"}, bus.err_count, err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.s         = '0;
        bus.t         = '0;
        bus.x         = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cand_ok",   bus.cand_ok, 0);
        check("rst_exists",    bus.exists, 0);
        check("rst_min_x",     bus.min_x, 0);
        check("rst_sat_count", bus.sat_count, 0);
        check("rst_error",     bus.error, 0);
        check("rst_chk_count", bus.chk_count, 0);
        check("rst_err_count", bus.err_count, 0);
        rst_n = 1'b1;

        // Directed vectors: s, t, x, cand_ok, min_x, sat_count, chk, err.
        run_vec("v_basic", 4'd3,  4'd9,  4'd6, 1'b1, 4'd6, 5'd7,  1, 0);
        run_vec("v_wrong", 4'd0,  4'd15, 4'd3, 1'b0, 4'd15, 5'd1, 2, 1);
        run_vec("v_wrap",  4'd10, 4'd12, 4'd3, 1'b1, 4'd2, 5'd4,  3, 1);
        run_vec("v_t0",    4'd5,  4'd0,  4'd9, 1'b1, 4'd0, 5'd16, 4, 1);
        run_vec("v_mix",   4'd15, 4'd8,  4'd1, 1'b0, 4'd0, 5'd8,  5, 2);

        // Backpressure with a competing request held on the inputs.
        accept(4'd3, 4'd9, 4'd6);
        wait_resp(n);
        check("bp_latency", n, 16);
        @(negedge clk);
        bus.s        = 4'd0;
        bus.t        = 4'd15;
        bus.x        = 4'd3;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_in_ready", bus.in_ready, 0);
            check_result("bp_hold", 1'b1, 4'd6, 5'd7);
        end
        handshake();
        check("bp_after_in_ready",  bus.in_ready, 1);
        check("bp_after_out_valid", bus.out_valid, 0);
        check("bp_chk_count", bus.chk_count, 6);
        check("bp_err_count", bus.err_count, 2);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second_accepted", bus.in_ready, 0);
        wait_resp(n);
        check("bp2_latency", n, 16);
        check_result("bp2", 1'b0, 4'd15, 5'd1);
        handshake();
        check("bp2_chk_count", bus.chk_count, 7);
        check("bp2_err_count", bus.err_count, 3);

        // Reset in the middle of a sweep (index 7) abandons the request.
        do_reset();
        accept(4'd0, 4'd15, 4'd3);
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        check("mid_rst_in_ready",  bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sat_count", bus.sat_count, 0);
        check("mid_rst_chk_count", bus.chk_count, 0);
        check("mid_rst_err_count", bus.err_count, 0);
        run_vec("v_post_rst", 4'd3, 4'd9, 4'd6, 1'b1, 4'd6, 5'd7, 1, 0);

        // Counter saturation: 256 more erroneous results.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            accept(4'd0, 4'd15, 4'd3);
            wait_resp(n);
            if (n != 16) check("sat_loop_latency", n, 16);
            handshake();
        end
        check("sat_chk_count", bus.chk_count, 255);
        check("sat_err_count", bus.err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bvuge_bvadd_witness_checker.md
BVUGE_BVADD_WITNESS_CHECKER -- requirements
Module: bvuge_bvadd_witness_checker

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the bit-vector width of s, t and x.
REQ-002 The block SHALL have parameter CW, default 8, giving the width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  a request (s, t, x) is presented.
REQ-006 in_ready  output  1  the block accepts a request.
REQ-007 s  input  W  the addend operand.
REQ-008 t  input  W  the bound operand.
REQ-009 x  input  W  the candidate witness from the Skolem generator.
REQ-010 out_valid  output  1  the result fields are valid.
REQ-011 out_ready  input  1  the consumer accepts the result.
REQ-012 cand_ok  output  1  1 when ((x + s) mod 2^W) >= t, unsigned.
REQ-013 exists  output  1  1 when at least one W-bit value satisfies the relation.
REQ-014 min_x  output  W  the smallest satisfying value; 0 when exists=0.
REQ-015 sat_count  output  W+1  the number of satisfying values, range 0..2^W.
REQ-016 error  output  1  equal to exists & ~cand_ok: the Skolem output was wrong.
REQ-017 chk_count  output  CW  the number of completed results; saturates at all-ones.
REQ-018 err_count  output  CW  the number of completed results with error=1; saturates at all-ones.

Function
REQ-019 The FSM SHALL have three states: IDLE, SWEEP and RESP.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge where in_valid=1 and in_ready=1.
REQ-022 On acceptance, the block SHALL register s, t and x, and compute cand_ok from the registered values.
REQ-023 On acceptance, the block SHALL clear the sweep index, sat_count, exists and min_x, and enter SWEEP.
REQ-024 In SWEEP, each edge SHALL evaluate one index i, in order 0..2^W-1, against ((i + s) mod 2^W) >= t.
REQ-025 For each satisfying i, sat_count SHALL increment; the first satisfying i SHALL load min_x and set exists.
REQ-026 The edge that evaluates i = 2^W-1 SHALL move the FSM to RESP.
REQ-027 out_valid SHALL be 1 only in RESP.
REQ-028 Latency from the accepting edge to out_valid=1 SHALL be exactly 2^W edges (16 for W=4).
REQ-029 Addition SHALL be W-bit modular, with carry-out discarded.
REQ-030 Comparison SHALL be unsigned.
REQ-031 The sweep index SHALL be W+1 bits wide, or the block SHALL use an explicit last flag, so that the sweep terminates without wrap ambiguity.
REQ-032 In RESP, all result outputs SHALL hold stable until an edge with out_ready=1.
REQ-033 On an edge in RESP with out_ready=1, the block SHALL return to IDLE.
REQ-034 On that same edge, chk_count SHALL increment by 1, and err_count SHALL increment by 1 if error=1.
REQ-035 chk_count and err_count SHALL saturate at 2^CW-1 and never wrap.
REQ-036 in_valid in SWEEP or RESP SHALL be ignored and SHALL NOT corrupt any state.
REQ-037 A new request SHALL be accepted no earlier than the edge after the return to IDLE; there is no overlap of requests.
REQ-038 exists SHALL equal 1 for every completed request, because x = ~s always yields 2^W-1 >= t; the sweep still computes exists independently.

Reset
REQ-039 When rst_n=0 at an edge, the block SHALL set the FSM to IDLE.
REQ-040 At reset: in_ready=1, out_valid=0, cand_ok=0, exists=0, min_x=0, sat_count=0, error=0.
REQ-041 At reset: chk_count=0, err_count=0, sweep index=0, and all operand registers=0.
REQ-042 Reset during SWEEP or RESP SHALL abandon the request, produce no result, and leave both counters at 0.

Verification
REQ-043 s=3, t=9, x=6 -> after 16 edges: cand_ok=1, exists=1, min_x=6, sat_count=7, error=0.
REQ-044 s=0, t=15, x=3 -> cand_ok=0, min_x=15, sat_count=1, error=1; err_count increments to 1 upon out_ready.
REQ-045 Wrap-around case: s=10, t=12, x=3 -> cand_ok=1, min_x=2, sat_count=4, error=0.
REQ-046 Bound zero: t=0, any s and x -> sat_count=16, min_x=0, cand_ok=1.
REQ-047 Backpressure: out_ready held 0 for 5 cycles in RESP, with in_valid=1 on other data -> outputs stable and in_ready=0; that data is not accepted until after the handshake.
REQ-048 Reset mid-sweep: rst_n=0 at sweep index 7, then a new request s=3, t=9, x=6 -> only one result is produced, matching REQ-043, with chk_count=1.
